// File: rtl/apb_master_if.sv
// Command/response handshake and APB bus signals of the apb_master requester.
// The master modport is the requester side; slave is the host-plus-APB-slave side.
interface apb_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on APB,
// valid/ready response out, with an optional ACCESS-phase timeout.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// RESP   | rsp_valid high until rsp_ready
module apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         pclk,
  input  logic         prst,
  apb_master_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit   TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q,   state_d;
  logic [ADDR_W-1:0] paddr_q,   paddr_d;
  logic              pwrite_q,  pwrite_d;
  logic [DATA_W-1:0] pwdata_q,  pwdata_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              err_q,     err_d;
  logic              tmo_q,     tmo_d;
  logic [CNT_W-1:0]  wcnt_q,    wcnt_d;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    wcnt_d   = wcnt_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        wcnt_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready wins over the timeout when both land on the last allowed cycle
        if (bus.pready) begin
          rdata_d = pwrite_q ? '0 : bus.prdata;
          err_d   = bus.pslverr;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (TO_EN && (wcnt_q == TO_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable     = (state_q == ACCESS);
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: one instance with the default timeout and one
// with TIMEOUT=4, sharing stimulus; sel chooses which instance is driven/observed.
module tb_apb_master;
  localparam int AW = 12;
  localparam int DW = 32;

  logic pclk = 1'b0;
  logic prst;
  always #5 pclk = ~pclk;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) if2 ();

  apb_master #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .pclk(pclk), .prst(prst), .bus(if1.master)
  );
  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) u_dut_to (
    .pclk(pclk), .prst(prst), .bus(if2.master)
  );

  logic          sel;
  logic          d_cmd_valid, d_cmd_write, d_rsp_ready, d_pready, d_pslverr;
  logic [AW-1:0] d_cmd_addr;
  logic [DW-1:0] d_cmd_wdata, d_prdata;

  assign if1.cmd_valid = d_cmd_valid & ~sel;
  assign if2.cmd_valid = d_cmd_valid & sel;
  assign if1.cmd_write = d_cmd_write;  assign if2.cmd_write = d_cmd_write;
  assign if1.cmd_addr  = d_cmd_addr;   assign if2.cmd_addr  = d_cmd_addr;
  assign if1.cmd_wdata = d_cmd_wdata;  assign if2.cmd_wdata = d_cmd_wdata;
  assign if1.rsp_ready = d_rsp_ready;  assign if2.rsp_ready = d_rsp_ready;
  assign if1.pready    = d_pready & ~sel;
  assign if2.pready    = d_pready & sel;
  assign if1.prdata    = d_prdata;     assign if2.prdata    = d_prdata;
  assign if1.pslverr   = d_pslverr;    assign if2.pslverr   = d_pslverr;

  logic          o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout;
  logic          o_psel, o_penable, o_pwrite;
  logic [AW-1:0] o_paddr;
  logic [DW-1:0] o_rsp_rdata, o_pwdata;

  assign o_cmd_ready   = sel ? if2.cmd_ready   : if1.cmd_ready;
  assign o_rsp_valid   = sel ? if2.rsp_valid   : if1.rsp_valid;
  assign o_rsp_rdata   = sel ? if2.rsp_rdata   : if1.rsp_rdata;
  assign o_rsp_err     = sel ? if2.rsp_err     : if1.rsp_err;
  assign o_rsp_timeout = sel ? if2.rsp_timeout : if1.rsp_timeout;
  assign o_psel        = sel ? if2.psel        : if1.psel;
  assign o_penable     = sel ? if2.penable     : if1.penable;
  assign o_pwrite      = sel ? if2.pwrite      : if1.pwrite;
  assign o_paddr       = sel ? if2.paddr       : if1.paddr;
  assign o_pwdata      = sel ? if2.pwdata      : if1.pwdata;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_psel",        o_psel, 0);
    chk("rst_penable",     o_penable, 0);
    chk("rst_pwrite",      o_pwrite, 0);
    chk("rst_paddr",       o_paddr, 0);
    chk("rst_pwdata",      o_pwdata, 0);
    chk("rst_rsp_valid",   o_rsp_valid, 0);
    chk("rst_rsp_rdata",   o_rsp_rdata, 0);
    chk("rst_rsp_err",     o_rsp_err, 0);
    chk("rst_rsp_timeout", o_rsp_timeout, 0);
    chk("rst_cmd_ready",   o_cmd_ready, 1);
  endtask

  // Issues one command and walks ACCESS; returns with the sample point in the
  // first cycle after ACCESS. pready rises in ACCESS cycle waits+1.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input logic [DW-1:0] rdata, input logic slverr,
                      output int acc);
    int guard;
    logic [DW-1:0] exp_pwdata;
    exp_pwdata = wr ? wdata : '0;
    guard = 0;
    while (!o_cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("cmd_ready_pre", o_cmd_ready, 1);
    d_cmd_valid = 1'b1;  d_cmd_write = wr;  d_cmd_addr = addr;  d_cmd_wdata = wdata;
    d_pready    = 1'b1;  d_pslverr   = 1'b1; d_prdata  = 32'hDEAD_DEAD;
    tick();
    d_cmd_valid = 1'b0;  d_cmd_addr  = '1;   d_cmd_wdata = '1;  d_cmd_write = ~wr;
    chk("setup_psel",    o_psel, 1);
    chk("setup_penable", o_penable, 0);
    chk("setup_paddr",   o_paddr, addr);
    tick();
    acc = 0;
    while (o_penable && acc < 300) begin
      acc++;
      chk("acc_psel",   o_psel, 1);
      chk("acc_paddr",  o_paddr, addr);
      chk("acc_pwrite", o_pwrite, wr);
      chk("acc_pwdata", o_pwdata, exp_pwdata);
      if (acc == waits + 1) begin
        d_pready = 1'b1;  d_prdata = rdata;   d_pslverr = slverr;
      end else begin
        d_pready = 1'b0;  d_prdata = ~rdata;  d_pslverr = ~slverr;
      end
      tick();
    end
    d_pready = 1'b0;  d_pslverr = 1'b0;  d_prdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    sel = 1'b0;
    d_cmd_valid = 0; d_cmd_write = 0; d_cmd_addr = '0; d_cmd_wdata = '0;
    d_rsp_ready = 1; d_pready = 0; d_prdata = '0; d_pslverr = 0;
    prst = 1'b1;
    tick(); tick();
    prst = 1'b0;
    chk_reset_vals();

    // zero-wait write: SETUP cycle 1, ACCESS cycle 2, response cycle 3
    xfer(1'b1, 12'h004, 32'hA5A5_0001, 0, 32'h0, 1'b0, acc);
    chk("wr0_access_cycles", acc, 1);
    chk("wr0_rsp_valid",     o_rsp_valid, 1);
    chk("wr0_rsp_rdata",     o_rsp_rdata, 0);
    chk("wr0_rsp_err",       o_rsp_err, 0);
    chk("wr0_rsp_timeout",   o_rsp_timeout, 0);
    chk("wr0_psel_resp",     o_psel, 0);
    tick();
    chk("wr0_idle_ready",    o_cmd_ready, 1);
    chk("wr0_idle_rsp",      o_rsp_valid, 0);
    chk("wr0_hold_paddr",    o_paddr, 12'h004);

    xfer(1'b0, 12'h010, 32'hFFFF_FFFF, 3, 32'h1234_5678, 1'b0, acc);
    chk("rd3_access_cycles", acc, 4);
    chk("rd3_rsp_valid",     o_rsp_valid, 1);
    chk("rd3_rsp_rdata",     o_rsp_rdata, 32'h1234_5678);
    chk("rd3_rsp_err",       o_rsp_err, 0);
    tick();

    xfer(1'b0, 12'hFFC, 32'h0, 0, 32'hCAFE_F00D, 1'b1, acc);
    chk("err_access_cycles", acc, 1);
    chk("err_rsp_err",       o_rsp_err, 1);
    chk("err_rsp_timeout",   o_rsp_timeout, 0);
    chk("err_rsp_rdata",     o_rsp_rdata, 32'hCAFE_F00D);
    tick();

    // reset held two cycles while a transfer is in ACCESS
    d_cmd_valid = 1; d_cmd_write = 0; d_cmd_addr = 12'h040; d_pready = 0;
    tick();
    d_cmd_valid = 0;
    tick(); tick();
    chk("mid_penable", o_penable, 1);
    prst = 1'b1;
    tick();
    chk("mid_rst_psel",      o_psel, 0);
    chk("mid_rst_cmd_ready", o_cmd_ready, 1);
    tick();
    prst = 1'b0;
    chk_reset_vals();
    tick();
    chk("mid_rst_stay_idle", o_psel, 0);

    // backpressure: response held 5 cycles with a new command already waiting
    d_rsp_ready = 1'b0;
    xfer(1'b0, 12'h020, 32'h0, 1, 32'h0BAD_BEEF, 1'b0, acc);
    chk("bp_access_cycles", acc, 2);
    d_cmd_valid = 1; d_cmd_write = 1; d_cmd_addr = 12'h030; d_cmd_wdata = 32'h0000_C0DE;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", o_rsp_valid, 1);
      chk("bp_rsp_rdata", o_rsp_rdata, 32'h0BAD_BEEF);
      chk("bp_rsp_err",   o_rsp_err, 0);
      chk("bp_cmd_ready", o_cmd_ready, 0);
      chk("bp_psel",      o_psel, 0);
      tick();
    end
    chk("bp_still_valid", o_rsp_valid, 1);
    d_rsp_ready = 1'b1;
    tick();
    chk("bp_idle_rsp_valid", o_rsp_valid, 0);
    chk("bp_idle_cmd_ready", o_cmd_ready, 1);
    chk("bp_idle_psel",      o_psel, 0);
    tick();
    d_cmd_valid = 0;
    chk("bp_next_setup",  o_psel, 1);
    chk("bp_next_paddr",  o_paddr, 12'h030);
    chk("bp_next_pwdata", o_pwdata, 32'h0000_C0DE);
    tick();
    d_pready = 1'b1;
    tick();
    d_pready = 1'b0;
    chk("bp_next_rsp",   o_rsp_valid, 1);
    chk("bp_next_rdata", o_rsp_rdata, 0);
    tick();

    // TIMEOUT=4 instance
    sel = 1'b1;
    chk("to_idle_ready", o_cmd_ready, 1);
    xfer(1'b0, 12'h100, 32'h0, 3, 32'h55AA_55AA, 1'b0, acc);
    chk("to_edge_cycles",  acc, 4);
    chk("to_edge_rdata",   o_rsp_rdata, 32'h55AA_55AA);
    chk("to_edge_err",     o_rsp_err, 0);
    chk("to_edge_timeout", o_rsp_timeout, 0);
    tick();

    xfer(1'b0, 12'h104, 32'h0, 1000, 32'h7777_7777, 1'b0, acc);
    chk("to_cycles",    acc, 4);
    chk("to_rsp_valid", o_rsp_valid, 1);
    chk("to_rsp_err",   o_rsp_err, 1);
    chk("to_timeout",   o_rsp_timeout, 1);
    chk("to_rdata",     o_rsp_rdata, 0);
    chk("to_psel",      o_psel, 0);
    tick();
    chk("to_idle_ready2", o_cmd_ready, 1);

    xfer(1'b1, 12'h108, 32'h0000_0001, 2, 32'h0, 1'b0, acc);
    chk("to_after_cycles",  acc, 3);
    chk("to_after_err",     o_rsp_err, 0);
    chk("to_after_timeout", o_rsp_timeout, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
